dmem_responder: RTL and testbench

- Memory-side responder for the core's MEM-stage load/store requests.
- Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Performs word, halfword or byte access on a little-endian word array, with optional sign extension on loads.
- Returns load data, and optionally a write acknowledge, over a valid/ready response channel.
- Gives the pipeline a realistic, stallable memory target in place of a zero-latency array.

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Stallable data-memory responder: valid/ready request in, WAIT_CYCLES wait states, response out.
// Optional feature: define DMEM_WRITE_ACK_EN to route stores through a response phase.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned AW          = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        err_sticky
);

    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_WAIT     = 2'd1;
    localparam logic [1:0]  S_RESP     = 2'd2;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);
`ifdef DMEM_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, sign_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  width_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d, sticky_q, sticky_d;

    logic [31:0] mem [DEPTH];

    logic        accept, do_access, to_resp;
    logic        acc_write, acc_sign, acc_err;
    logic [31:0] acc_addr, acc_wdata;
    logic [1:0]  acc_width;
    logic [AW-1:0] acc_idx;
    logic [31:0] word_rd, st_word, ld_data;
    logic [15:0] half_rd;
    logic [7:0]  byte_rd;

    assign req_ready  = (state_q == S_IDLE) && reset;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign err_sticky = sticky_q;
    assign accept     = req_valid && req_ready;

    // With zero wait states the access uses the live request on its acceptance edge.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_width = req_width;
            acc_sign  = req_sign;
        end else begin
            acc_write = write_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_width = width_q;
            acc_sign  = sign_q;
        end
    end

    assign acc_idx   = acc_addr[AW+1:2];
    assign do_access = (state_q == S_WAIT && cnt_q == 4'd1) || (accept && WAIT_CYCLES == 0);
    assign to_resp   = !acc_write || WRITE_ACK;
    assign acc_err   = (acc_width == 2'b11)
                     || ({1'b0, acc_addr} >= ADDR_LIMIT)
                     || (acc_width == 2'b00 && acc_addr[1:0] != 2'b00)
                     || (acc_width == 2'b01 && acc_addr[0]);

    always_comb begin
        word_rd = mem[acc_idx];
        half_rd = acc_addr[1] ? word_rd[31:16] : word_rd[15:0];
        byte_rd = word_rd[{acc_addr[1:0], 3'b000} +: 8];
        case (acc_width)
            2'b00:   ld_data = word_rd;
            2'b01:   ld_data = {{16{acc_sign & half_rd[15]}}, half_rd};
            2'b10:   ld_data = {{24{acc_sign & byte_rd[7]}}, byte_rd};
            default: ld_data = 32'd0;
        endcase
        st_word = word_rd;
        case (acc_width)
            2'b00:   st_word = acc_wdata;
            2'b01:   st_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
            2'b10:   st_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
            default: st_word = word_rd;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        sticky_d = sticky_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = to_resp ? S_RESP : S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = to_resp ? S_RESP : S_IDLE;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_access) begin
            rdata_d = (acc_err || acc_write) ? 32'd0 : ld_data;
            err_d   = acc_err;
            if (acc_err) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            width_q  <= 2'b00;
            sign_q   <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                width_q <= req_width;
                sign_q  <= req_sign;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_access && acc_write && !acc_err) begin
            mem[acc_idx] <= st_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus randomized traffic against a
// byte-array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH       = 1024;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam int unsigned AW          = 10;
    localparam int unsigned BYTES       = 4 * DEPTH;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_width;
    logic        req_sign;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        err_sticky;

    dmem_responder #(
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAIT_CYCLES),
        .AW         (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_width (req_width),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  ref_mem [BYTES];
    logic        sticky_exp = 1'b0;
    logic [31:0] got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] a, input logic [1:0] w);
        return (w == 2'b11) || (a >= BYTES) || (w == 2'b00 && (a % 4) != 0)
            || (w == 2'b01 && (a % 2) != 0);
    endfunction

    function automatic int ref_nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 4 : (w == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w,
                                             input logic s);
        logic [31:0] v = 32'd0;
        int n = ref_nbytes(w);
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        int n = ref_nbytes(w);
        for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(d >> (8 * i));
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] wd, input logic s);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_width = wd;
        req_sign  = s;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_width = 2'($urandom);
        req_sign  = 1'($urandom);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), WAIT_CYCLES);
    endtask

    task automatic finish_rsp(input string tag, input int hold, input logic [31:0] exp_d);
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, exp_d);
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic load_op(input string tag, input logic [31:0] a, input logic [1:0] wd,
                           input logic s, input int hold, output logic [31:0] obs);
        logic        exp_e = ref_err(a, wd);
        logic [31:0] exp_d = exp_e ? 32'd0 : ref_load(a, wd, s);
        issue(1'b0, a, 32'($urandom), wd, s);
        check({tag, "_busy"}, 32'(req_ready), 32'd0);
        wait_rsp(tag);
        obs = rsp_rdata;
        if (exp_e) sticky_exp = 1'b1;
        check({tag, "_rdata"}, rsp_rdata, exp_d);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        check({tag, "_sticky"}, 32'(err_sticky), 32'(sticky_exp));
        finish_rsp(tag, hold, exp_d);
    endtask

    task automatic store_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] wd);
        logic exp_e = ref_err(a, wd);
        issue(1'b1, a, d, wd, 1'($urandom));
        if (exp_e) sticky_exp = 1'b1;
        else ref_store(a, d, wd);
`ifdef DMEM_WRITE_ACK_EN
        wait_rsp(tag);
        check({tag, "_ack_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_ack_err"}, 32'(rsp_err), 32'(exp_e));
        finish_rsp(tag, 0, 32'd0);
`else
        begin
            logic saw = rsp_valid;
            repeat (WAIT_CYCLES) begin
                @(posedge clk); #1;
                if (rsp_valid) saw = 1'b1;
            end
            check({tag, "_no_rsp"}, 32'(saw), 32'd0);
            check({tag, "_back_idle"}, 32'(req_ready), 32'd1);
        end
`endif
        check({tag, "_sticky"}, 32'(err_sticky), 32'(sticky_exp));
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_width = 2'b00;
        req_sign  = 1'b0;
        rsp_ready = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);
        check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rel_sticky", 32'(err_sticky), 32'd0);
        check("rel_rdata", rsp_rdata, 32'd0);
        check("rel_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;

        store_op("st_w0", 32'h0, 32'h0102_0304, 2'b00);
        store_op("st_w10", 32'h10, 32'hDEAD_BEEF, 2'b00);
        load_op("ld_w10", 32'h10, 2'b00, 1'b0, 0, got);
        check("ld_w10_value", got, 32'hDEAD_BEEF);
        store_op("st_b11", 32'h11, 32'h0000_005A, 2'b10);
        load_op("ld_w10b", 32'h10, 2'b00, 1'b1, 0, got);
        check("ld_w10b_value", got, 32'hDEAD_5AEF);
        load_op("ld_b13s", 32'h13, 2'b10, 1'b1, 0, got);
        check("ld_b13s_value", got, 32'hFFFF_FFDE);
        load_op("ld_b13u", 32'h13, 2'b10, 1'b0, 0, got);
        check("ld_b13u_value", got, 32'h0000_00DE);
        load_op("ld_h12s", 32'h12, 2'b01, 1'b1, 0, got);
        check("ld_h12s_value", got, 32'hFFFF_DEAD);
        check("sticky_clean", 32'(err_sticky), 32'd0);

        load_op("ld_w12_mis", 32'h12, 2'b00, 1'b0, 0, got);
        check("ld_w12_sticky", 32'(err_sticky), 32'd1);
        store_op("st_oor", BYTES, 32'hFFFF_FFFF, 2'b00);
        load_op("ld_w0_after_oor", 32'h0, 2'b00, 1'b0, 0, got);
        check("ld_w0_unchanged", got, 32'h0102_0304);
        load_op("ld_backpressure", 32'h10, 2'b00, 1'b0, 5, got);

        for (int i = 0; i < 16; i++) store_op("init", 32'(4 * i), $urandom, 2'b00);
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            logic [1:0]  wd;
            a  = ($urandom_range(0, 9) == 0) ? BYTES + $urandom_range(0, 7)
                                             : 32'($urandom_range(0, 63));
            wd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) store_op("rnd_st", a, $urandom, wd);
            else load_op("rnd_ld", a, wd, 1'($urandom), $urandom_range(0, 2), got);
        end

        store_op("st_w20", 32'h20, 32'hCAFE_F00D, 2'b00);
        issue(1'b1, 32'h20, 32'h1234_5678, 2'b00, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        sticky_exp = 1'b0;
        #1;
        check("midrst_rel_ready", 32'(req_ready), 32'd1);
        check("midrst_rel_sticky", 32'(err_sticky), 32'd0);
        @(posedge clk); #1;
        load_op("ld_w20_after_rst", 32'h20, 2'b00, 1'b0, 0, got);
        check("ld_w20_prior", got, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
